reg_xfer_sequencer: RTL and testbench

- Control-side stage directly upstream of the register unit. It drives the per-register control strobes that the register unit consumes.
- Accepts one decoded instruction byte per handshake: MOV8, SETAB or ALU.
- Sequences relay-style select/load/hold pulses: source register drives the data bus, the destination latches, then the source releases.
- Fixed, parameterised timing mimics relay settle behaviour.

---
 rtl/relay_pkg.sv | 44 ++++
 rtl/xfer_decode.sv | 40 ++++
 rtl/reg_xfer_sequencer.sv | 95 +++++++++
 tb/tb_reg_xfer_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// Shared types for the relay-style register transfer sequencer:
// register ids, opcode prefixes, FSM states and the decoded control word.
package relay_pkg;

  typedef enum logic [2:0] {
    REG_A  = 3'd0,
    REG_B  = 3'd1,
    REG_C  = 3'd2,
    REG_D  = 3'd3,
    REG_M1 = 3'd4,
    REG_M2 = 3'd5,
    REG_X  = 3'd6,
    REG_Y  = 3'd7
  } reg_id_e;

  localparam logic [1:0] OP_MOV8  = 2'b00;
  localparam logic [1:0] OP_SETAB = 2'b01;
  localparam logic [3:0] OP_ALU   = 4'b1000;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [7:0] sel;
    reg_id_e    ld_idx;
    logic       imm_en;
    logic [7:0] imm_val;
    logic       alu_en;
    logic [2:0] alu_fn;
    logic       illegal;
  } xfer_ctrl_t;

  function automatic logic [7:0] reg_bit(input reg_id_e r);
    reg_bit = 8'b1 << r;
  endfunction

endpackage

// File: rtl/xfer_decode.sv
// Combinational decode of one instruction byte into the control word
// that the sequencer latches at acceptance.
module xfer_decode
  import relay_pkg::*;
(
  input  logic [7:0] instr,
  output xfer_ctrl_t ctrl
);

  logic [2:0] d;
  logic [2:0] s;

  assign d = instr[5:3];
  assign s = instr[2:0];

  always_comb begin
    ctrl = '0;
    if (instr[7:6] == OP_MOV8) begin
      ctrl.ld_idx = reg_id_e'(d);
      // Moving a register onto itself is repurposed as a clear via the immediate path
      if (d == s) begin
        ctrl.imm_en  = 1'b1;
        ctrl.imm_val = 8'h00;
      end else begin
        ctrl.sel = reg_bit(reg_id_e'(s));
      end
    end else if (instr[7:6] == OP_SETAB) begin
      ctrl.imm_en  = 1'b1;
      ctrl.imm_val = {{3{instr[4]}}, instr[4:0]};
      ctrl.ld_idx  = instr[5] ? REG_B : REG_A;
    end else if (instr[7:4] == OP_ALU) begin
      ctrl.alu_en = 1'b1;
      ctrl.alu_fn = instr[2:0];
      ctrl.ld_idx = instr[3] ? REG_D : REG_A;
    end else begin
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/reg_xfer_sequencer.sv
// Relay-style transfer sequencer: drives the bus source, pulses the destination
// load after a settle window, then holds the source before reporting done.
module reg_xfer_sequencer
  import relay_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic [7:0] sel,
  output logic [7:0] ld,
  output logic       imm_en,
  output logic [7:0] imm_val,
  output logic       alu_en,
  output logic [2:0] alu_fn,
  output seq_state_e state_dbg
);

  // Handshake: start is taken only on a cycle where busy=0; busy then stays
  // high through the done cycle, so any start seen while busy is dropped.

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  seq_state_e       state;
  xfer_ctrl_t       ctrl_q;
  xfer_ctrl_t       dec;
  logic [CNT_W-1:0] cnt;
  logic             src_on;

  xfer_decode u_decode (
    .instr (instr),
    .ctrl  (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      ctrl_q <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ctrl_q <= dec;
            if (dec.illegal) begin
              state <= ST_DONE;
            end else begin
              state <= ST_SETTLE;
              cnt   <= SETTLE_LOAD;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) state <= ST_LOAD;
          else           cnt   <= cnt - 1'b1;
        end
        ST_LOAD: begin
          if (HOLD_CYCLES == 0) begin
            state <= ST_DONE;
          end else begin
            state <= ST_HOLD;
            cnt   <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes depend only on flops, never on start/instr directly
  assign src_on    = (state == ST_SETTLE) || (state == ST_LOAD) || (state == ST_HOLD);
  assign sel       = src_on ? ctrl_q.sel : 8'h00;
  assign imm_en    = src_on & ctrl_q.imm_en;
  assign imm_val   = (src_on && ctrl_q.imm_en) ? ctrl_q.imm_val : 8'h00;
  assign alu_en    = src_on & ctrl_q.alu_en;
  assign alu_fn    = (src_on && ctrl_q.alu_en) ? ctrl_q.alu_fn : 3'b000;
  assign ld        = (state == ST_LOAD) ? reg_bit(ctrl_q.ld_idx) : 8'h00;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign illegal   = done & ctrl_q.illegal;
  assign state_dbg = state;

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Scoreboard bench for reg_xfer_sequencer: default timing instance plus a
// SETTLE=1/HOLD=0 instance, checked cycle by cycle against expected traces.
module tb_reg_xfer_sequencer;
  import relay_pkg::*;

  logic clk;
  logic reset;

  // default-parameter instance
  logic       start, busy, done, illegal, imm_en, alu_en;
  logic [7:0] instr, sel, ld, imm_val;
  logic [2:0] alu_fn;
  seq_state_e state_dbg;

  // SETTLE_CYCLES=1, HOLD_CYCLES=0 instance
  logic       start2, busy2, done2, illegal2, imm_en2, alu_en2;
  logic [7:0] instr2, sel2, ld2, imm_val2;
  logic [2:0] alu_fn2;
  seq_state_e state_dbg2;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_q2[$];

  reg_xfer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .busy(busy), .done(done), .illegal(illegal), .sel(sel), .ld(ld),
    .imm_en(imm_en), .imm_val(imm_val), .alu_en(alu_en), .alu_fn(alu_fn),
    .state_dbg(state_dbg)
  );

  reg_xfer_sequencer #(.SETTLE_CYCLES(1), .HOLD_CYCLES(0)) dut_fast (
    .clk(clk), .reset(reset), .start(start2), .instr(instr2),
    .busy(busy2), .done(done2), .illegal(illegal2), .sel(sel2), .ld(ld2),
    .imm_en(imm_en2), .imm_val(imm_val2), .alu_en(alu_en2), .alu_fn(alu_fn2),
    .state_dbg(state_dbg2)
  );

  logic [31:0] act, act2;
  assign act  = {busy, done, illegal, sel, ld, imm_en, imm_val, alu_en, alu_fn};
  assign act2 = {busy2, done2, illegal2, sel2, ld2, imm_en2, imm_val2, alu_en2, alu_fn2};

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pk(input logic b, input logic d, input logic il,
                                     input logic [7:0] s, input logic [7:0] l,
                                     input logic ie, input logic [7:0] iv,
                                     input logic ae, input logic [2:0] af);
    return {b, d, il, s, l, ie, iv, ae, af};
  endfunction

  // Expected per-cycle trace from cycle 1 after acceptance, ending with one idle cycle.
  // abort_after>0 keeps only that many cycles, modelling a reset in that cycle.
  task automatic push_run(input bit fast, input int settle, input int hold,
                          input logic [7:0] s, input logic [7:0] l,
                          input logic ie, input logic [7:0] iv,
                          input logic ae, input logic [2:0] af,
                          input bit ill, input int abort_after);
    logic [31:0] v[$];
    if (ill) begin
      v.push_back(pk(1'b1, 1'b1, 1'b1, '0, '0, 1'b0, '0, 1'b0, '0));
    end else begin
      repeat (settle) v.push_back(pk(1'b1, 1'b0, 1'b0, s, '0, ie, iv, ae, af));
      v.push_back(pk(1'b1, 1'b0, 1'b0, s, l, ie, iv, ae, af));
      repeat (hold) v.push_back(pk(1'b1, 1'b0, 1'b0, s, '0, ie, iv, ae, af));
      v.push_back(pk(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0));
    end
    if (abort_after > 0) while (v.size() > abort_after) void'(v.pop_back());
    v.push_back('0);
    foreach (v[i]) begin
      if (fast) exp_q2.push_back(v[i]);
      else      exp_q.push_back(v[i]);
    end
  endtask

  // ---------------- driver tasks (called at negedge = cycle 0) ----------------
  task automatic drive(input bit fast, input logic [7:0] ins);
    if (fast) begin start2 = 1'b1; instr2 = ins; end
    else      begin start  = 1'b1; instr  = ins; end
  endtask

  task automatic release_start();
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_q2.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || exp_q2.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending entries, want 0", exp_q.size(), exp_q2.size());
      exp_q.delete();
      exp_q2.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL trace_default: got %h want %h (busy,done,ill,sel,ld,ie,iv,ae,af)", act, e);
        end
      end
      if (exp_q2.size() != 0) begin
        e = exp_q2.pop_front();
        checks++;
        if (act2 !== e) begin
          errors++;
          $display("FAIL trace_fast: got %h want %h (busy,done,ill,sel,ld,ie,iv,ae,af)", act2, e);
        end
      end
      if (ld != 8'h00) begin
        checks++;
        if (!$onehot(ld) || !((|sel) || imm_en || alu_en)) begin
          errors++;
          $display("FAIL ld_without_source_default: got ld=%h sel=%h ie=%b ae=%b want onehot ld with a source", ld, sel, imm_en, alu_en);
        end
      end
      if (ld2 != 8'h00) begin
        checks++;
        if (!$onehot(ld2) || !((|sel2) || imm_en2 || alu_en2)) begin
          errors++;
          $display("FAIL ld_without_source_fast: got ld=%h sel=%h ie=%b ae=%b want onehot ld with a source", ld2, sel2, imm_en2, alu_en2);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;  instr  = 8'h00;
    start2 = 1'b0; instr2 = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (act !== 32'h0 || act2 !== 32'h0 || state_dbg != ST_IDLE || state_dbg2 != ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %h/%h state %0d/%0d want 0/0 state IDLE", act, act2, state_dbg, state_dbg2);
    end
    reset = 1'b0;
    @(negedge clk);

    // MOV8 B<-C
    drive(1'b0, 8'h0A); push_run(1'b0, 2, 1, 8'h04, 8'h02, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 0);
    release_start(); drain();
    // SETAB B = -1
    drive(1'b0, 8'h7F); push_run(1'b0, 2, 1, 8'h00, 8'h02, 1'b1, 8'hFF, 1'b0, 3'b000, 1'b0, 0);
    release_start(); drain();
    // SETAB A = 15
    drive(1'b0, 8'h4F); push_run(1'b0, 2, 1, 8'h00, 8'h01, 1'b1, 8'h0F, 1'b0, 3'b000, 1'b0, 0);
    release_start(); drain();
    // SETAB A = -16
    drive(1'b0, 8'h50); push_run(1'b0, 2, 1, 8'h00, 8'h01, 1'b1, 8'hF0, 1'b0, 3'b000, 1'b0, 0);
    release_start(); drain();
    // ALU fn 5 -> D
    drive(1'b0, 8'h8D); push_run(1'b0, 2, 1, 8'h00, 8'h08, 1'b0, 8'h00, 1'b1, 3'b101, 1'b0, 0);
    release_start(); drain();
    // ALU fn 2 -> A
    drive(1'b0, 8'h82); push_run(1'b0, 2, 1, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1, 3'b010, 1'b0, 0);
    release_start(); drain();
    // MOV8 M1<-M1 is a clear
    drive(1'b0, 8'h24); push_run(1'b0, 2, 1, 8'h00, 8'h10, 1'b1, 8'h00, 1'b0, 3'b000, 1'b0, 0);
    release_start(); drain();
    // MOV8 Y<-A
    drive(1'b0, 8'h38); push_run(1'b0, 2, 1, 8'h01, 8'h80, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 0);
    release_start(); drain();
    // illegal opcodes
    drive(1'b0, 8'h95); push_run(1'b0, 2, 1, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 0);
    release_start(); drain();
    drive(1'b0, 8'hF0); push_run(1'b0, 2, 1, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 0);
    release_start(); drain();

    // starts in cycles 2 and 5 of a run must be ignored
    drive(1'b0, 8'h0A); push_run(1'b0, 2, 1, 8'h04, 8'h02, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 0);
    release_start();                       // cycle 1
    @(negedge clk); drive(1'b0, 8'h01);    // cycle 2
    release_start();                       // cycle 3
    @(negedge clk);                        // cycle 4
    @(negedge clk); drive(1'b0, 8'h01);    // cycle 5
    release_start();                       // cycle 6
    drain();

    // reset in cycle 3 aborts; new start in cycle 5 runs normally
    drive(1'b0, 8'h0A); push_run(1'b0, 2, 1, 8'h04, 8'h02, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 3);
    release_start();                       // cycle 1
    @(negedge clk);                        // cycle 2
    @(negedge clk); reset = 1'b1;          // cycle 3
    @(negedge clk); reset = 1'b0;          // cycle 4
    @(negedge clk);                        // cycle 5
    drive(1'b0, 8'h0A); push_run(1'b0, 2, 1, 8'h04, 8'h02, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 0);
    release_start(); drain();

    // short-timing instance
    drive(1'b1, 8'h0A); push_run(1'b1, 1, 0, 8'h04, 8'h02, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 0);
    release_start(); drain();
    drive(1'b1, 8'h7F); push_run(1'b1, 1, 0, 8'h00, 8'h02, 1'b1, 8'hFF, 1'b0, 3'b000, 1'b0, 0);
    release_start(); drain();
    drive(1'b1, 8'h8D); push_run(1'b1, 1, 0, 8'h00, 8'h08, 1'b0, 8'h00, 1'b1, 3'b101, 1'b0, 0);
    release_start(); drain();
    drive(1'b1, 8'h95); push_run(1'b1, 1, 0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 0);
    release_start(); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
